// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requests, one registered resp pulse per grant.
// Define MEM_ARB_RR_EN for round-robin arbitration on simultaneous requests (default: data over inst).
module mem_port_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inst_read,
  input  logic [WIDTH-1:0]   inst_addr,
  output logic [WIDTH-1:0]   inst_rdata,
  output logic               inst_resp,
  input  logic               data_read,
  input  logic               data_write,
  input  logic [WIDTH-1:0]   data_addr,
  input  logic [WIDTH-1:0]   data_wdata,
  input  logic [WIDTH/8-1:0] data_mbe,
  output logic [WIDTH-1:0]   data_rdata,
  output logic               data_resp,
  output logic               mem_read,
  output logic               mem_write,
  output logic [WIDTH-1:0]   mem_addr,
  output logic [WIDTH-1:0]   mem_wdata,
  output logic [WIDTH/8-1:0] mem_byte_enable,
  input  logic [WIDTH-1:0]   mem_rdata,
  input  logic               mem_resp
);
  localparam int BW = WIDTH / 8;
  typedef enum logic [1:0] {IDLE, INST, DATA, DONE} state_t;
  state_t           state_q, state_d;
  logic             side_q, side_d, we_q, we_d, gnt_data;
  logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, irdata_q, irdata_d, drdata_q, drdata_d;
  logic [BW-1:0]    mbe_q, mbe_d;
`ifdef MEM_ARB_RR_EN
  logic             rr_q, rr_d;
  assign gnt_data = (data_read | data_write) & (!inst_read | rr_q);
`else
  assign gnt_data = data_read | data_write;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      side_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mbe_q    <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      rr_q     <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      side_q   <= side_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mbe_q    <= mbe_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
`ifdef MEM_ARB_RR_EN
      rr_q     <= rr_d;
`endif
    end
  end
  always_comb begin
    state_d  = state_q;
    side_d   = side_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mbe_d    = mbe_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
`ifdef MEM_ARB_RR_EN
    rr_d     = rr_q;
`endif
    unique case (state_q)
      IDLE: if (gnt_data | inst_read) begin
        state_d = gnt_data ? DATA : INST;
        side_d  = gnt_data;
        we_d    = gnt_data & data_write;
        addr_d  = gnt_data ? data_addr : inst_addr;
        wdata_d = gnt_data ? data_wdata : '0;
        mbe_d   = (gnt_data & data_write) ? data_mbe : '1;
      end
      INST, DATA: if (mem_resp) begin
        state_d = DONE;
        if (state_q == INST) irdata_d = mem_rdata;
        else if (!we_q) drdata_d = mem_rdata;
      end
      DONE: begin
        state_d = IDLE;
`ifdef MEM_ARB_RR_EN
        rr_d    = !rr_q;
`endif
      end
    endcase
  end
  always_comb begin
    mem_read        = (state_q == INST) | ((state_q == DATA) & !we_q);
    mem_write       = (state_q == DATA) & we_q;
    inst_resp       = (state_q == DONE) & !side_q;
    data_resp       = (state_q == DONE) & side_q;
    mem_addr        = addr_q;
    mem_wdata       = wdata_q;
    mem_byte_enable = mbe_q;
    inst_rdata      = irdata_q;
    data_rdata      = drdata_q;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus, per-cycle transaction-level model compare plus literal checks.
module tb_mem_port_arbiter;
  logic        clk = 0, rst = 0;
  logic        inst_read = 0, data_read = 0, data_write = 0, mem_resp, inst_resp, data_resp;
  logic [31:0] inst_addr = 0, data_addr = 0, data_wdata = 0, mem_rdata;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic [3:0]  data_mbe = 0, mem_byte_enable;
  logic        mem_read, mem_write;
  int          checks = 0, failures = 0;
  int          lat = 1;
  logic [31:0] rd_val = 0;
  logic        idle_resp = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .inst_read(inst_read), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_resp(inst_resp),
    .data_read(data_read), .data_write(data_write), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_mbe(data_mbe), .data_rdata(data_rdata), .data_resp(data_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
    end
  endtask

  // Transaction-level model: one pending transaction, then one response cycle.
  logic        m_busy, m_done, m_isdata, m_we, m_rr, md;
  logic [31:0] m_addr, m_wdata, m_ir, m_dr;
  logic [3:0]  m_mbe;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_done = 0; m_isdata = 0; m_we = 0; m_rr = 1;
      m_addr = 0; m_wdata = 0; m_mbe = 0; m_ir = 0; m_dr = 0;
    end else if (m_done) begin
      m_done = 0;
      m_rr = !m_rr;
    end else if (m_busy) begin
      if (mem_resp) begin
        m_busy = 0;
        m_done = 1;
        if (!m_isdata) m_ir = mem_rdata;
        else if (!m_we) m_dr = mem_rdata;
      end
    end else begin
      md = data_read | data_write;
`ifdef MEM_ARB_RR_EN
      md = md & (!inst_read | m_rr);
`endif
      if (md | inst_read) begin
        m_busy = 1;
        m_isdata = md;
        m_we = md & data_write;
        m_addr = md ? data_addr : inst_addr;
        m_wdata = data_wdata;
        m_mbe = m_we ? data_mbe : 4'hF;
      end
    end
  end

  always @(negedge clk) begin
    chk("mem_read", mem_read, m_busy & !m_we);
    chk("mem_write", mem_write, m_busy & m_we);
    chk("mem_byte_enable", mem_byte_enable, m_mbe);
    if (m_busy) chk("mem_addr", mem_addr, m_addr);
    if (m_busy & m_we) chk("mem_wdata", mem_wdata, m_wdata);
    chk("inst_resp", inst_resp, m_done & !m_isdata);
    chk("data_resp", data_resp, m_done & m_isdata);
    chk("inst_rdata", inst_rdata, m_ir);
    chk("data_rdata", data_rdata, m_dr);
    chk("resp_exclusive", inst_resp & data_resp, 0);
  end

  initial begin
    int cnt;
    cnt = 0;
    mem_resp = 0;
    mem_rdata = 0;
    forever begin
      @(posedge clk); #1;
      mem_rdata = rd_val;
      if (mem_read | mem_write) begin
        cnt++;
        mem_resp = (cnt == lat);
        if (cnt == lat) cnt = 0;
      end else begin
        cnt = 0;
        mem_resp = idle_resp;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    string ord;
    int starts, resps, found;
    logic prev;
    #7;
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_inst_resp", inst_resp, 0);
    chk("rst_data_resp", data_resp, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mbe", mem_byte_enable, 0);
    chk("rst_inst_rdata", inst_rdata, 0);
    chk("rst_data_rdata", data_rdata, 0);
    step();
    rst = 1;
    idle_resp = 1;
    repeat (3) step();
    chk("idle_resp_ignored_read", mem_read, 0);
    chk("idle_resp_ignored_iresp", inst_resp, 0);
    idle_resp = 0;
    step();
    // Fetch with 3-cycle memory latency
    lat = 3; rd_val = 32'h13; inst_addr = 32'h60; inst_read = 1;
    for (int c = 1; c <= 3; c++) begin
      step();
      chk("fetch_mem_read", mem_read, 1);
      chk("fetch_mem_addr", mem_addr, 32'h60);
      chk("fetch_no_early_resp", inst_resp, 0);
    end
    step();
    chk("fetch_inst_resp", inst_resp, 1);
    chk("fetch_inst_rdata", inst_rdata, 32'h13);
    chk("fetch_strobe_off", mem_read, 0);
    inst_read = 0;
    step();
    chk("fetch_resp_one_cycle", inst_resp, 0);
    // Store with single-cycle memory response
    lat = 1; rd_val = 32'h5555AAAA;
    data_write = 1; data_addr = 32'h100; data_wdata = 32'hDEADBEEF; data_mbe = 4'h3;
    step();
    chk("store_mem_write", mem_write, 1);
    chk("store_mem_read", mem_read, 0);
    chk("store_addr", mem_addr, 32'h100);
    chk("store_wdata", mem_wdata, 32'hDEADBEEF);
    chk("store_mbe", mem_byte_enable, 4'h3);
    step();
    chk("store_data_resp", data_resp, 1);
    chk("store_strobe_off", mem_write, 0);
    chk("store_rdata_kept", data_rdata, 0);
    data_write = 0;
    step();
    chk("store_resp_one_cycle", data_resp, 0);
    // Read and write together act as a write
    data_read = 1; data_write = 1; data_addr = 32'h104; data_wdata = 32'h1234; data_mbe = 4'hC;
    step();
    chk("rw_is_write", mem_write, 1);
    chk("rw_no_read", mem_read, 0);
    step();
    data_read = 0; data_write = 0;
    repeat (2) step();
    // Simultaneous requests after reset: data wins either way
    do_reset();
    lat = 2; rd_val = 32'hCAFE0001; inst_addr = 32'h200; data_addr = 32'h300;
    inst_read = 1; data_read = 1; ord = "";
    for (int c = 0; c < 40 && ord.len() < 2; c++) begin
      step();
      if (data_resp) begin ord = {ord, "D"}; data_read = 0; end
      if (inst_resp) begin ord = {ord, "I"}; inst_read = 0; end
    end
    chk_str("simul_order", ord, "DI");
    inst_read = 0; data_read = 0;
    repeat (2) step();
    // Both held for four transactions
    do_reset();
    lat = 1; rd_val = 32'h00C0FFEE; inst_read = 1; data_read = 1; ord = "";
    for (int c = 0; c < 60 && ord.len() < 4; c++) begin
      step();
      if (data_resp) ord = {ord, "D"};
      if (inst_resp) ord = {ord, "I"};
    end
    inst_read = 0; data_read = 0;
`ifdef MEM_ARB_RR_EN
    chk_str("held_order", ord, "DIDI");
`else
    chk_str("held_order", ord, "DDDD");
`endif
    repeat (3) step();
    // Continuously held fetch: one strobe episode per resp
    lat = 1; rd_val = 32'h77; inst_addr = 32'h400; inst_read = 1;
    starts = 0; resps = 0; prev = 0;
    for (int c = 0; c < 21; c++) begin
      step();
      if (c == 15) inst_read = 0;
      if (mem_read && !prev) starts++;
      if (inst_resp) resps++;
      prev = mem_read;
    end
    chk("hold_strobe_per_resp", starts, resps);
    chk("hold_enough_resps", resps >= 4, 1);
    // Reset while a read is outstanding
    lat = 10; inst_addr = 32'h44; inst_read = 1;
    repeat (2) step();
    chk("mid_rst_strobe_before", mem_read, 1);
    #2;
    rst = 0;
    #1;
    chk("mid_rst_strobe_dropped", mem_read, 0);
    chk("mid_rst_addr_cleared", mem_addr, 0);
    inst_read = 0;
    step();
    rst = 1;
    found = 0;
    repeat (8) begin
      step();
      if (inst_resp | data_resp) found++;
    end
    chk("mid_rst_no_resp", found, 0);
    lat = 2; rd_val = 32'hABCD; inst_addr = 32'h80; inst_read = 1; found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      step();
      if (inst_resp) found = 1;
    end
    chk("post_rst_grant", found, 1);
    chk("post_rst_rdata", inst_rdata, 32'hABCD);
    inst_read = 0;
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the pipeline's instruction-fetch and data-access requests onto the single shared memory port and generates the `inst_resp` / `data_resp` pulses the pipeline's stage-load logic consumes. It sits between the pipeline front end (fetch and memory stages) and the cache/physical memory. It latches the winning request, holds it on the memory port until `mem_resp`, then returns one registered response pulse with read data to the winning requester.

## Interface
- `WIDTH`, default 32: width of the address and data buses.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `inst_read`  input  1  instruction fetch request; held by the requester until `inst_resp`.
- `inst_addr`  input  WIDTH  fetch address.
- `inst_rdata`  output  WIDTH  fetched instruction; valid while `inst_resp`=1.
- `inst_resp`  output  1  one-cycle fetch-complete pulse.
- `data_read`  input  1  data load request; held until `data_resp`.
- `data_write`  input  1  data store request; held until `data_resp`.
- `data_addr`  input  WIDTH  load/store address.
- `data_wdata`  input  WIDTH  store data.
- `data_mbe`  input  WIDTH/8  store byte enables.
- `data_rdata`  output  WIDTH  load data; valid while `data_resp`=1.
- `data_resp`  output  1  one-cycle data-complete pulse.
- `mem_read`  output  1  memory read strobe; held until `mem_resp`.
- `mem_write`  output  1  memory write strobe; held until `mem_resp`.
- `mem_addr`  output  WIDTH  latched address.
- `mem_wdata`  output  WIDTH  latched store data.
- `mem_byte_enable`  output  WIDTH/8  latched byte enables; all ones for reads.
- `mem_rdata`  input  WIDTH  memory read data, valid with `mem_resp`.
- `mem_resp`  input  1  memory completion.

## Operation
- States: IDLE, INST, DATA, DONE.
- IDLE: sample requests. A data request (`data_read` or `data_write`) goes to DATA. Otherwise, `inst_read` goes to INST. Otherwise, stay in IDLE.
- On the grant edge, latch `mem_addr`, `mem_wdata`, `mem_byte_enable` and the op type.
  - If `data_read` and `data_write` are both 1, treat the request as a write.
- INST/DATA: `mem_read` or `mem_write` is driven from state and latched op. They stay at 1 until `mem_resp`.
  - Latched fields are frozen.
  - Requester input changes are ignored.
- On `mem_resp` in INST/DATA:
  - Go to DONE.
  - Register `mem_rdata` into `inst_rdata` or `data_rdata` (writes leave `data_rdata` unchanged).
  - Set the matching `*_resp`.
- DONE: the `*_resp` pulse is high for exactly this cycle. No request sampling. The next state is IDLE unconditionally.
  - This cycle gives the requester one edge to drop or change its request, so a held request is never re-granted.
- A request withdrawn mid-transaction still completes on the memory port, and its resp is still pulsed.
- `inst_resp` and `data_resp` are never 1 in the same cycle.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE.
  - `mem_read`=`mem_write`=0.
  - `inst_resp`=`data_resp`=0.
  - `mem_addr`, `mem_wdata`, `inst_rdata`, `data_rdata`=0.
  - `mem_byte_enable`=0.
  - Round-robin pointer (if enabled) points to data.
- Reset mid-transaction: strobes drop with no clock, no resp is issued, and the pending transaction is abandoned.
- Request seen in IDLE at edge 0: strobe high in cycle 1.
- `mem_resp` sampled at edge k: `*_resp` high in cycle k+1, IDLE in cycle k+2.
- Minimum request-to-resp latency is 2 cycles (`mem_resp` in the first strobe cycle).
- Back-to-back: the next grant is sampled in IDLE, giving a 2-cycle gap between strobe episodes.
- `mem_resp` outside INST/DATA is ignored.

## Configuration
- `MEM_ARB_RR_EN` undefined: fixed priority, data over instruction.
- `MEM_ARB_RR_EN` defined: a 1-bit round-robin pointer is added.
  - It is used only when data and instruction requests are both present in IDLE.
  - The side indicated by the pointer wins.
  - The pointer flips to the other side on every DONE.
  - Single-sided requests are granted regardless of the pointer.

## Test plan
- Fetch, memory 3-cycle latency:
  - Stimulus: `inst_read`=1 with `inst_addr`=0x60 at edge 0; `mem_resp` in cycles 1-3 is 0,0,1 with `mem_rdata`=0x00000013.
  - Required: `mem_read`=1 and `mem_addr`=0x60 in cycles 1-3; `inst_resp`=1 and `inst_rdata`=0x13 in cycle 4 only.
- Store:
  - Stimulus: `data_write`=1, `data_addr`=0x100, `data_wdata`=0xDEADBEEF, `data_mbe`=0x3, with `mem_resp` in the first strobe cycle.
  - Required: `mem_write`=1 with those values for one cycle; `data_resp` pulses one cycle later; `mem_read` stays 0.
- Simultaneous `inst_read` and `data_read`, macro undefined:
  - Required: data is served first, then inst. `data_resp` and `inst_resp` are never high together.
- Same as above, macro defined, both requests held for 4 transactions:
  - Required: grants alternate data, inst, data, inst.
- Hold request through resp:
  - Stimulus: `inst_read` held at 1 continuously.
  - Required: exactly one memory read per `inst_resp`; no duplicate strobe in DONE.
- Reset mid-operation:
  - Stimulus: `rst`=0 asserted off-edge while `mem_read`=1.
  - Required: `mem_read`=0 immediately; no resp after release; the next request is granted normally.
